// File: rtl/lane_runner_core_pkg.sv
// Shared definitions for the lane-runner player/rules core.
//   state_t      : game state encoding (also driven on db_state)
//   map_index    : bit position of (row, lane) in a flattened map
//   count_width  : bits needed to hold the larger of two counts
package lane_runner_core_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PLAYING = 3'd1,
      S_INVULN  = 3'd2,
      S_OVER    = 3'd3,
      S_WON     = 3'd4
   } state_t;

   function automatic int unsigned map_index(input int unsigned row,
                                             input int unsigned lane,
                                             input int unsigned lanes);
      return row * lanes + lane;
   endfunction

   function automatic int unsigned count_width(input int unsigned a,
                                               input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/lane_runner_core_footprint.sv
// lane_footprint_reduce: ORs each lane of a flattened map over the rows
// ROW_LO..ROW_HI (the player footprint).
//   map   in  ROWS*LANES  flattened map, bit r*LANES+l = row r, lane l
//   lanes out LANES       per-lane OR over the footprint rows
module lane_footprint_reduce
   import lane_runner_core_pkg::*;
#(
   parameter int unsigned LANES  = 4,
   parameter int unsigned ROWS   = 128,
   parameter int unsigned ROW_LO = 0,
   parameter int unsigned ROW_HI = 23
) (
   input  logic [ROWS*LANES-1:0] map,
   output logic [LANES-1:0]      lanes
);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [ROW_HI-ROW_LO:0] column;
      for (genvar r = ROW_LO; r <= ROW_HI; r++) begin : g_row
         assign column[r-ROW_LO] = map[map_index(r, l, LANES)];
      end
      assign lanes[l] = |column;
   end

endmodule

// File: rtl/lane_runner_core.sv
// lane_runner_core: player lane, hit/pickup detection, lives, invulnerability,
// score and win/lose control for lane-runner games.
//   clock, reset (async, active-high)
//   start, dificuldade        : new game request and lives selection
//   btn_left, btn_right       : level buttons, edge-detected here
//   map_obstacles/objectives  : flattened scrolling maps
//   player_lane (one-hot, MSB leftmost), lives, score
//   hit_pulse, clear_objective: 1-cycle event pulses
//   invulnerable, game_over, game_won, db_state: status
module lane_runner_core
   import lane_runner_core_pkg::*;
#(
   parameter int unsigned LANES         = 4,
   parameter int unsigned ROWS          = 128,
   parameter int unsigned ROW_LO        = 0,
   parameter int unsigned ROW_HI        = 23,
   parameter int unsigned LIVES_EASY    = 3,
   parameter int unsigned LIVES_HARD    = 1,
   parameter int unsigned INVULN_CYCLES = 50000,
   parameter int unsigned GOAL          = 7
) (
   input  logic                                              clock,
   input  logic                                              reset,
   input  logic                                              start,
   input  logic                                              dificuldade,
   input  logic                                              btn_left,
   input  logic                                              btn_right,
   input  logic [ROWS*LANES-1:0]                             map_obstacles,
   input  logic [ROWS*LANES-1:0]                             map_objectives,
   output logic [LANES-1:0]                                  player_lane,
   output logic [count_width(LIVES_EASY, LIVES_HARD)-1:0]    lives,
   output logic [$clog2(GOAL+1)-1:0]                         score,
   output logic                                              hit_pulse,
   output logic [LANES-1:0]                                  clear_objective,
   output logic                                              invulnerable,
   output logic                                              game_over,
   output logic                                              game_won,
   output logic [2:0]                                        db_state
);

   localparam int unsigned LW = count_width(LIVES_EASY, LIVES_HARD);
   localparam int unsigned SW = $clog2(GOAL + 1);
   localparam int unsigned TW = $clog2(INVULN_CYCLES + 1);

   state_t            state, next_state;
   logic              left_q, right_q, left_edge, right_edge;
   logic [LANES-1:0]  obs_lanes, obj_lanes;
   logic [TW-1:0]     timer;
   logic              lockout;
   logic              active, hit_now, got_now, count_hit, fatal, collect, win, start_ok;
   logic [SW-1:0]     score_inc;

   lane_footprint_reduce #(.LANES(LANES), .ROWS(ROWS), .ROW_LO(ROW_LO), .ROW_HI(ROW_HI))
      u_obs (.map(map_obstacles), .lanes(obs_lanes));

   lane_footprint_reduce #(.LANES(LANES), .ROWS(ROWS), .ROW_LO(ROW_LO), .ROW_HI(ROW_HI))
      u_obj (.map(map_objectives), .lanes(obj_lanes));

   assign left_edge  = btn_left  & ~left_q;
   assign right_edge = btn_right & ~right_q;

   always_comb begin
      active    = (state == S_PLAYING) || (state == S_INVULN);
      start_ok  = start && ((state == S_IDLE) || (state == S_OVER) || (state == S_WON));
      hit_now   = |(obs_lanes & player_lane);
      got_now   = |(obj_lanes & player_lane);
      count_hit = (state == S_PLAYING) && hit_now;
      fatal     = count_hit && (lives == LW'(1));
      // A fatal hit swallows a same-cycle pickup, including a winning one.
      collect   = active && got_now && !lockout && !fatal;
      score_inc = (score == SW'(GOAL)) ? score : score + SW'(1);
      win       = collect && (score_inc == SW'(GOAL));
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:    if (start_ok) next_state = S_PLAYING;
         S_PLAYING: begin
            if (fatal)          next_state = S_OVER;
            else if (win)       next_state = S_WON;
            else if (count_hit) next_state = S_INVULN;
         end
         S_INVULN: begin
            if (win)                               next_state = S_WON;
            else if (timer == TW'(INVULN_CYCLES-1)) next_state = S_PLAYING;
         end
         S_OVER, S_WON: if (start_ok) next_state = S_PLAYING;
         default:   next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         left_q          <= 1'b0;
         right_q         <= 1'b0;
         player_lane     <= {1'b1, {(LANES-1){1'b0}}};
         lives           <= '0;
         score           <= '0;
         timer           <= '0;
         lockout         <= 1'b0;
         hit_pulse       <= 1'b0;
         clear_objective <= '0;
      end else begin
         left_q          <= btn_left;
         right_q         <= btn_right;
         hit_pulse       <= count_hit;
         clear_objective <= collect ? player_lane : '0;
         lockout         <= collect;
         if (start_ok) begin
            lives       <= dificuldade ? LW'(LIVES_HARD) : LW'(LIVES_EASY);
            score       <= '0;
            player_lane <= {1'b1, {(LANES-1){1'b0}}};
            timer       <= '0;
            lockout     <= 1'b0;
         end else begin
            if (count_hit) lives <= lives - LW'(1);
            if (collect)   score <= score_inc;
            if (count_hit)              timer <= '0;
            else if (state == S_INVULN) timer <= timer + TW'(1);
            // Left edge takes priority; at the left wall it still swallows a right edge.
            if (active) begin
               if (left_edge) begin
                  if (!player_lane[LANES-1]) player_lane <= {player_lane[LANES-2:0], 1'b0};
               end else if (right_edge && !player_lane[0]) begin
                  player_lane <= {1'b0, player_lane[LANES-1:1]};
               end
            end
         end
      end
   end

   assign invulnerable = (state == S_INVULN);
   assign game_over    = (state == S_OVER);
   assign game_won     = (state == S_WON);
   assign db_state     = state;

endmodule

// File: tb/tb_lane_runner_core.sv
// Directed bench for lane_runner_core (INVULN_CYCLES overridden to 20).
module tb_lane_runner_core;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         dificuldade = 1'b0;
   logic         btn_left = 1'b0;
   logic         btn_right = 1'b0;
   logic [511:0] map_obstacles = '0;
   logic [511:0] map_objectives = '0;
   logic [3:0]   player_lane;
   logic [1:0]   lives;
   logic [2:0]   score;
   logic         hit_pulse;
   logic [3:0]   clear_objective;
   logic         invulnerable, game_over, game_won;
   logic [2:0]   db_state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] lane;
      logic [1:0] lv;
      logic [2:0] sc;
      logic [2:0] st;
      logic       hit;
      logic [3:0] clr;
   } exp_t;

   exp_t exp_q[$];

   lane_runner_core #(.INVULN_CYCLES(20)) dut (
      .clock(clock), .reset(reset), .start(start), .dificuldade(dificuldade),
      .btn_left(btn_left), .btn_right(btn_right),
      .map_obstacles(map_obstacles), .map_objectives(map_objectives),
      .player_lane(player_lane), .lives(lives), .score(score),
      .hit_pulse(hit_pulse), .clear_objective(clear_objective),
      .invulnerable(invulnerable), .game_over(game_over), .game_won(game_won),
      .db_state(db_state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input exp_t e);
      chk("player_lane", 32'(player_lane), 32'(e.lane));
      chk("lives", 32'(lives), 32'(e.lv));
      chk("score", 32'(score), 32'(e.sc));
      chk("db_state", 32'(db_state), 32'(e.st));
      chk("hit_pulse", 32'(hit_pulse), 32'(e.hit));
      chk("clear_objective", 32'(clear_objective), 32'(e.clr));
      chk("invulnerable", 32'(invulnerable), 32'(e.st == 3'd2));
      chk("game_over", 32'(game_over), 32'(e.st == 3'd3));
      chk("game_won", 32'(game_won), 32'(e.st == 3'd4));
   endtask

   // Expected post-edge outputs are queued as the stimulus is driven,
   // then popped and compared once the DUT has clocked it.
   task automatic cyc(input logic [3:0] lane, input logic [1:0] lv, input logic [2:0] sc,
                      input logic [2:0] st, input logic hit = 1'b0, input logic [3:0] clr = 4'b0);
      exp_t e;
      e.lane = lane; e.lv = lv; e.sc = sc; e.st = st; e.hit = hit; e.clr = clr;
      exp_q.push_back(e);
      @(posedge clock); #1;
      e = exp_q.pop_front();
      check_all(e);
   endtask

   task automatic press_left(input logic [3:0] lane, input logic [1:0] lv, input logic [2:0] sc,
                             input logic [2:0] st);
      btn_left = 1'b1; cyc(lane, lv, sc, st);
      btn_left = 1'b0; cyc(lane, lv, sc, st);
   endtask

   task automatic press_right(input logic [3:0] lane, input logic [1:0] lv, input logic [2:0] sc,
                              input logic [2:0] st);
      btn_right = 1'b1; cyc(lane, lv, sc, st);
      btn_right = 1'b0; cyc(lane, lv, sc, st);
   endtask

   // 20 cycles of invulnerability: 19 more in INVULN after entry, then PLAYING.
   task automatic inv_run(input logic [3:0] lane, input logic [1:0] lv, input logic [2:0] sc);
      for (int i = 0; i < 19; i++) cyc(lane, lv, sc, 3'd2);
      cyc(lane, lv, sc, 3'd1);
   endtask

   initial begin
      exp_t r;
      r.lane = 4'b1000; r.lv = 2'd0; r.sc = 3'd0; r.st = 3'd0; r.hit = 1'b0; r.clr = 4'b0;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      check_all(r);
      reset = 1'b0;
      cyc(4'b1000, 0, 0, 3'd0);

      // 1: easy start, left at the left wall
      start = 1'b1; dificuldade = 1'b0;
      cyc(4'b1000, 3, 0, 3'd1);
      start = 1'b0;
      press_left(4'b1000, 3, 0, 3'd1);

      // 2: rightward moves, right wall, simultaneous edges
      press_right(4'b0100, 3, 0, 3'd1);
      press_right(4'b0010, 3, 0, 3'd1);
      press_right(4'b0001, 3, 0, 3'd1);
      press_right(4'b0001, 3, 0, 3'd1);
      press_left(4'b0010, 3, 0, 3'd1);
      btn_left = 1'b1; btn_right = 1'b1;
      cyc(4'b0100, 3, 0, 3'd1);
      btn_left = 1'b0; btn_right = 1'b0;
      cyc(4'b0100, 3, 0, 3'd1);
      press_left(4'b1000, 3, 0, 3'd1);

      // 3: held obstacle row 5 lane 3
      map_obstacles[23] = 1'b1;
      cyc(4'b1000, 2, 0, 3'd2, 1'b1);
      inv_run(4'b1000, 2, 0);
      cyc(4'b1000, 1, 0, 3'd2, 1'b1);
      map_obstacles[23] = 1'b0;
      inv_run(4'b1000, 1, 0);

      // 4: fatal hit, frozen in OVER, hard restart, start ignored while playing
      map_obstacles[23] = 1'b1;
      cyc(4'b1000, 0, 0, 3'd3, 1'b1);
      map_obstacles[23] = 1'b0;
      press_right(4'b1000, 0, 0, 3'd3);
      start = 1'b1; dificuldade = 1'b1;
      cyc(4'b1000, 1, 0, 3'd1);
      dificuldade = 1'b0;
      cyc(4'b1000, 1, 0, 3'd1);
      start = 1'b0;
      map_obstacles[23] = 1'b1;
      cyc(4'b1000, 0, 0, 3'd3, 1'b1);
      map_obstacles[23] = 1'b0;
      start = 1'b1; dificuldade = 1'b1;
      cyc(4'b1000, 1, 0, 3'd1);
      start = 1'b0; dificuldade = 1'b0;

      // 5: pickups in lane 1 up to GOAL; obstacle row 30 lane 1 must never hit
      press_right(4'b0100, 1, 0, 3'd1);
      press_right(4'b0010, 1, 0, 3'd1);
      map_obstacles[121] = 1'b1;
      map_objectives[41] = 1'b1;
      cyc(4'b0010, 1, 1, 3'd1, 1'b0, 4'b0010);
      cyc(4'b0010, 1, 1, 3'd1);            // generator lags: lockout blocks recount
      map_objectives[41] = 1'b0;
      cyc(4'b0010, 1, 1, 3'd1);
      for (int k = 2; k <= 7; k++) begin
         map_objectives[41] = 1'b1;
         cyc(4'b0010, 1, 3'(k), (k == 7) ? 3'd4 : 3'd1, 1'b0, 4'b0010);
         map_objectives[41] = 1'b0;
         cyc(4'b0010, 1, 3'(k), (k == 7) ? 3'd4 : 3'd1);
      end
      map_objectives[41] = 1'b1;
      cyc(4'b0010, 1, 7, 3'd4);
      map_objectives[41] = 1'b0;
      press_right(4'b0010, 1, 7, 3'd4);

      // 6: same-cycle hit + pickup
      start = 1'b1;
      cyc(4'b1000, 3, 0, 3'd1);
      start = 1'b0;
      map_obstacles[3] = 1'b1;
      cyc(4'b1000, 2, 0, 3'd2, 1'b1);
      map_obstacles[3] = 1'b0;
      inv_run(4'b1000, 2, 0);
      map_obstacles[3] = 1'b1; map_objectives[43] = 1'b1;
      cyc(4'b1000, 1, 1, 3'd2, 1'b1, 4'b1000);
      map_obstacles[3] = 1'b0; map_objectives[43] = 1'b0;
      inv_run(4'b1000, 1, 1);
      map_obstacles[3] = 1'b1; map_objectives[43] = 1'b1;
      cyc(4'b1000, 0, 1, 3'd3, 1'b1);
      map_obstacles[3] = 1'b0; map_objectives[43] = 1'b0;

      // asynchronous reset mid-game
      start = 1'b1;
      cyc(4'b1000, 3, 0, 3'd1);
      start = 1'b0;
      press_right(4'b0100, 3, 0, 3'd1);
      #2 reset = 1'b1;
      #1 check_all(r);
      @(posedge clock); #1;
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
